controlador_carga_blocos: RTL and testbench

Sequences block transfers between the HD and the 16-block RAM, and owns the RAM block header table (valid bit + 31-bit name).
Accepts one OS command at a time (load, write-back or free) over a valid/ready handshake. For a load it allocates the lowest free RAM block and copies the block word by word from HD to RAM. It sits between the OS/processor control path and the RAM/HD memory modules.

---
 rtl/controlador_carga_blocos_pkg.sv | 37 +++
 rtl/controlador_carga_blocos_tabela_cabecalhos.sv | 52 +++++
 rtl/controlador_carga_blocos.sv | 216 +++++++++++++++++++++
 tb/tb_controlador_carga_blocos.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_carga_blocos_pkg.sv
// ============================================================================
// controlador_carga_blocos_pkg
// Shared encodings for the HD <-> RAM block transfer controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package controlador_carga_blocos_pkg;

  localparam int N_BLOCOS_RAM = 16;
  localparam int RAM_BLK_W    = 4;
  localparam int VALID_BIT    = 31;
  localparam int NOME_W       = 31;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_CARGA  = 2'b01,
    OP_WB     = 2'b10,
    OP_LIBERA = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSCA = 2'd1,
    COPIA = 2'd2,
    FIM   = 2'd3
  } estado_t;

  // Header word layout: bit 31 = valid, bits 30:0 = block name.
  function automatic logic [31:0] monta_cabecalho(input logic valido,
                                                  input logic [NOME_W-1:0] nome);
    return {valido, nome};
  endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_carga_blocos_tabela_cabecalhos.sv
// ============================================================================
// tabela_cabecalhos
// 16x32 RAM block header register file: one write port, two async read ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tabela_cabecalhos
  import controlador_carga_blocos_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [RAM_BLK_W-1:0]    wr_idx,
  input  logic [31:0]             wr_dado,
  input  logic [RAM_BLK_W-1:0]    busca_idx,
  output logic [31:0]             busca_dado,
  input  logic [RAM_BLK_W-1:0]    hdr_idx,
  output logic [31:0]             hdr_dado,
  output logic [N_BLOCOS_RAM-1:0] ocupados
);

  logic [31:0] hdr_q [N_BLOCOS_RAM];
  logic [31:0] hdr_d [N_BLOCOS_RAM];

  always_comb begin
    hdr_d = hdr_q;
    if (wr_en) begin
      hdr_d[wr_idx] = wr_dado;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BLOCOS_RAM; i++) begin
        hdr_q[i] <= '0;
      end
    end else begin
      hdr_q <= hdr_d;
    end
  end

  assign busca_dado = hdr_q[busca_idx];
  assign hdr_dado   = hdr_q[hdr_idx];

  for (genvar g = 0; g < N_BLOCOS_RAM; g++) begin : g_ocupados
    assign ocupados[g] = hdr_q[g][VALID_BIT];
  end

endmodule

`default_nettype wire

// File: rtl/controlador_carga_blocos.sv
// ============================================================================
// controlador_carga_blocos
// Sequences load / write-back / free commands between HD and the 16-block RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module controlador_carga_blocos
  import controlador_carga_blocos_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 64,
  parameter int HD_BLOCKS       = 64,
  parameter int OFS_W           = $clog2(WORDS_PER_BLOCK),
  parameter int HDB_W           = $clog2(HD_BLOCKS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [HDB_W-1:0]           cmd_hd_bloco,
  input  logic [RAM_BLK_W-1:0]       cmd_ram_bloco,
  input  logic [NOME_W-1:0]          cmd_nome,
  output logic [HDB_W+OFS_W-1:0]     hd_addr,
  input  logic [31:0]                hd_rdata,
  output logic [31:0]                hd_wdata,
  output logic                       hd_we,
  output logic [RAM_BLK_W+OFS_W-1:0] ram_addr,
  input  logic [31:0]                ram_rdata,
  output logic [31:0]                ram_wdata,
  output logic                       ram_we,
  output logic                       done,
  output logic                       erro,
  output logic [RAM_BLK_W-1:0]       bloco_resultado,
  output logic [N_BLOCOS_RAM-1:0]    ocupados,
  input  logic [RAM_BLK_W-1:0]       hdr_idx,
  output logic [31:0]                hdr_dado
);

  // The copy runs offsets 0..W, so the counter carries one extra bit.
  localparam logic [OFS_W:0] OFS_FIM = (OFS_W+1)'(WORDS_PER_BLOCK);

  estado_t               estado_q, estado_d;
  op_t                   op_q, op_d;
  logic [HDB_W-1:0]      hd_bloco_q, hd_bloco_d;
  logic [NOME_W-1:0]     nome_q, nome_d;
  logic [RAM_BLK_W-1:0]  bloco_q, bloco_d;
  logic [RAM_BLK_W-1:0]  cursor_q, cursor_d;
  logic [OFS_W:0]        ofs_q, ofs_d;
  logic                  erro_q, erro_d;

  logic                  tab_we;
  logic [RAM_BLK_W-1:0]  tab_idx;
  logic [31:0]           tab_dado;
  logic [RAM_BLK_W-1:0]  busca_idx;
  logic [31:0]           busca_dado;

  tabela_cabecalhos u_tabela (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (tab_we),
    .wr_idx     (tab_idx),
    .wr_dado    (tab_dado),
    .busca_idx  (busca_idx),
    .busca_dado (busca_dado),
    .hdr_idx    (hdr_idx),
    .hdr_dado   (hdr_dado),
    .ocupados   (ocupados)
  );

  // While idle the scan port looks at the commanded block (write-back/free check).
  assign busca_idx = (estado_q == IDLE) ? cmd_ram_bloco : cursor_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= IDLE;
      op_q       <= OP_NOP;
      hd_bloco_q <= '0;
      nome_q     <= '0;
      bloco_q    <= '0;
      cursor_q   <= '0;
      ofs_q      <= '0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      op_q       <= op_d;
      hd_bloco_q <= hd_bloco_d;
      nome_q     <= nome_d;
      bloco_q    <= bloco_d;
      cursor_q   <= cursor_d;
      ofs_q      <= ofs_d;
      erro_q     <= erro_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    op_d       = op_q;
    hd_bloco_d = hd_bloco_q;
    nome_d     = nome_q;
    bloco_d    = bloco_q;
    cursor_d   = cursor_q;
    ofs_d      = ofs_q;
    erro_d     = erro_q;
    tab_we     = 1'b0;
    tab_idx    = '0;
    tab_dado   = '0;

    case (estado_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d       = op_t'(cmd_op);
          hd_bloco_d = cmd_hd_bloco;
          nome_d     = cmd_nome;
          bloco_d    = cmd_ram_bloco;
          cursor_d   = '0;
          ofs_d      = '0;
          erro_d     = 1'b0;
          case (op_t'(cmd_op))
            OP_CARGA: begin
              bloco_d  = '0;
              estado_d = BUSCA;
            end
            OP_WB: begin
              if (busca_dado[VALID_BIT]) begin
                estado_d = COPIA;
              end else begin
                erro_d   = 1'b1;
                estado_d = FIM;
              end
            end
            OP_LIBERA: begin
              erro_d   = ~busca_dado[VALID_BIT];
              tab_we   = 1'b1;
              tab_idx  = cmd_ram_bloco;
              tab_dado = monta_cabecalho(1'b0, busca_dado[NOME_W-1:0]);
              estado_d = FIM;
            end
            default: estado_d = FIM;
          endcase
        end
      end

      BUSCA: begin
        if (!busca_dado[VALID_BIT]) begin
          tab_we   = 1'b1;
          tab_idx  = cursor_q;
          tab_dado = monta_cabecalho(1'b1, nome_q);
          bloco_d  = cursor_q;
          ofs_d    = '0;
          estado_d = COPIA;
        end else if (cursor_q == RAM_BLK_W'(N_BLOCOS_RAM - 1)) begin
          erro_d   = 1'b1;
          estado_d = FIM;
        end else begin
          cursor_d = cursor_q + RAM_BLK_W'(1);
        end
      end

      COPIA: begin
        if (ofs_q == OFS_FIM) begin
          estado_d = FIM;
        end else begin
          ofs_d = ofs_q + (OFS_W+1)'(1);
        end
      end

      default: estado_d = IDLE;
    endcase
  end

  logic             em_copia;
  logic             escrevendo;
  logic [OFS_W-1:0] ofs_rd;
  logic [OFS_W-1:0] ofs_wr;

  // Read address leads by one offset; the write trails it by the memory latency.
  assign em_copia   = (estado_q == COPIA);
  assign escrevendo = em_copia && (ofs_q != '0);
  assign ofs_rd     = ofs_q[OFS_W-1:0];
  assign ofs_wr     = ofs_rd - OFS_W'(1);

  always_comb begin
    hd_addr   = '0;
    ram_addr  = '0;
    hd_we     = 1'b0;
    ram_we    = 1'b0;
    hd_wdata  = '0;
    ram_wdata = '0;
    if (em_copia) begin
      if (op_q == OP_CARGA) begin
        hd_addr  = {hd_bloco_q, ofs_rd};
        ram_addr = {bloco_q, ofs_wr};
        ram_we   = escrevendo;
        if (escrevendo) begin
          ram_wdata = hd_rdata;
        end
      end else begin
        ram_addr = {bloco_q, ofs_rd};
        hd_addr  = {hd_bloco_q, ofs_wr};
        hd_we    = escrevendo;
        if (escrevendo) begin
          hd_wdata = ram_rdata;
        end
      end
    end
  end

  assign cmd_ready       = (estado_q == IDLE);
  assign done            = (estado_q == FIM);
  assign erro            = done & erro_q;
  assign bloco_resultado = bloco_q;

endmodule

`default_nettype wire

// File: tb/tb_controlador_carga_blocos.sv
// ============================================================================
// tb_controlador_carga_blocos
// Directed bench with a header/memory model for controlador_carga_blocos.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_controlador_carga_blocos;
  import controlador_carga_blocos_pkg::*;

  localparam int W     = 4;
  localparam int HDB   = 64;
  localparam int OFS_W = 2;
  localparam int HDB_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [HDB_W-1:0]  cmd_hd_bloco;
  logic [3:0]        cmd_ram_bloco;
  logic [30:0]       cmd_nome;
  logic [HDB_W+OFS_W-1:0] hd_addr;
  logic [31:0]       hd_rdata;
  logic [31:0]       hd_wdata;
  logic              hd_we;
  logic [4+OFS_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic              done;
  logic              erro;
  logic [3:0]        bloco_resultado;
  logic [15:0]       ocupados;
  logic [3:0]        hdr_idx;
  logic [31:0]       hdr_dado;

  controlador_carga_blocos #(
    .WORDS_PER_BLOCK (W),
    .HD_BLOCKS       (HDB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_hd_bloco    (cmd_hd_bloco),
    .cmd_ram_bloco   (cmd_ram_bloco),
    .cmd_nome        (cmd_nome),
    .hd_addr         (hd_addr),
    .hd_rdata        (hd_rdata),
    .hd_wdata        (hd_wdata),
    .hd_we           (hd_we),
    .ram_addr        (ram_addr),
    .ram_rdata       (ram_rdata),
    .ram_wdata       (ram_wdata),
    .ram_we          (ram_we),
    .done            (done),
    .erro            (erro),
    .bloco_resultado (bloco_resultado),
    .ocupados        (ocupados),
    .hdr_idx         (hdr_idx),
    .hdr_dado        (hdr_dado)
  );

  always #5 clk = ~clk;

  // Environment memories (what the DUT actually wrote) and expected contents.
  logic [31:0] hd_mem  [HDB*W];
  logic [31:0] ram_mem [16*W];
  logic [31:0] exp_hd  [HDB*W];
  logic [31:0] exp_ram [16*W];
  logic [31:0] m_hdr   [16];

  int n_total = 0;
  int n_bad   = 0;
  int n_hdwe  = 0;
  int n_ramwe = 0;

  function automatic logic [31:0] pat_hd(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  function automatic logic [31:0] pat_ram(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    for (int i = 0; i < HDB*W; i++) hd_mem[i] = pat_hd(i);
    for (int i = 0; i < 16*W; i++) ram_mem[i] = pat_ram(i);
    hd_rdata  = '0;
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      hd_rdata  <= hd_mem[hd_addr];
      ram_rdata <= ram_mem[ram_addr];
      if (hd_we)  hd_mem[hd_addr]   = hd_wdata;
      if (ram_we) ram_mem[ram_addr] = ram_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [15:0] ocup_model();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = m_hdr[i][31];
    return r;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (hd_we)  n_hdwe++;
        if (ram_we) n_ramwe++;
        chk("we_exclusivo", 32'(hd_we & ram_we), 32'd0);
        if (cmd_ready) begin
          chk("ocupados", 32'(ocupados), 32'(ocup_model()));
          chk("hdr_dado", hdr_dado, m_hdr[hdr_idx]);
          chk("done_ocioso", 32'(done), 32'd0);
        end
      end
    end
  endtask

  task automatic chk_mem();
    int bh = 0;
    int br = 0;
    for (int i = 0; i < HDB*W; i++) if (hd_mem[i] !== exp_hd[i]) bh++;
    for (int i = 0; i < 16*W; i++) if (ram_mem[i] !== exp_ram[i]) br++;
    chk("hd_mem_diffs", 32'(bh), 32'd0);
    chk("ram_mem_diffs", 32'(br), 32'd0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input int hd_b, input int ram_b,
                         input logic [30:0] nome, input bit noise,
                         output int lat, output logic [3:0] res);
    int   exp_lat  = 1;
    logic exp_err  = 1'b0;
    int   exp_res  = -1;
    int   exp_nhd  = 0;
    int   exp_nram = 0;
    int   slot     = -1;
    int   hd0, rm0;
    bit   got = 0;
    logic [31:0] new_hdr [16];
    new_hdr = m_hdr;
    case (op)
      2'b01: begin
        for (int i = 15; i >= 0; i--) if (!m_hdr[i][31]) slot = i;
        if (slot < 0) begin
          exp_err = 1'b1;
          exp_lat = 17;
        end else begin
          exp_lat  = slot + W + 3;
          exp_res  = slot;
          exp_nram = W;
          new_hdr[slot] = {1'b1, nome};
          for (int k = 0; k < W; k++) exp_ram[slot*W+k] = exp_hd[hd_b*W+k];
        end
      end
      2'b10: begin
        if (m_hdr[ram_b][31]) begin
          exp_lat = W + 2;
          exp_res = ram_b;
          exp_nhd = W;
          for (int k = 0; k < W; k++) exp_hd[hd_b*W+k] = exp_ram[ram_b*W+k];
        end else begin
          exp_err = 1'b1;
        end
      end
      2'b11: begin
        exp_err = !m_hdr[ram_b][31];
        if (!exp_err) exp_res = ram_b;
        new_hdr[ram_b][31] = 1'b0;
      end
      default: ;
    endcase

    @(negedge clk);
    chk("ready_antes", 32'(cmd_ready), 32'd1);
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_hd_bloco  = HDB_W'(hd_b);
    cmd_ram_bloco = 4'(ram_b);
    cmd_nome      = nome;
    hd0 = n_hdwe;
    rm0 = n_ramwe;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    lat = 0;
    while (lat < 60 && !got) begin
      @(negedge clk);
      lat++;
      hdr_idx = hdr_idx + 4'd1;
      if (noise) begin
        if (lat < 3) begin
          cmd_valid     = 1'b1;
          cmd_op        = 2'b11;
          cmd_ram_bloco = 4'd0;
        end else begin
          cmd_valid = 1'b0;
          cmd_op    = 2'b00;
        end
      end
      if (done) got = 1;
    end
    chk("done_visto", 32'(got), 32'd1);
    chk("latencia", 32'(lat), 32'(exp_lat));
    chk("erro", 32'(erro), 32'(exp_err));
    if (exp_res >= 0) chk("bloco_resultado", 32'(bloco_resultado), 32'(exp_res));
    res = bloco_resultado;
    #1;
    chk("n_ram_we", 32'(n_ramwe - rm0), 32'(exp_nram));
    chk("n_hd_we", 32'(n_hdwe - hd0), 32'(exp_nhd));
    m_hdr = new_hdr;
    chk_mem();
  endtask

  initial begin : main
    int lat;
    logic [3:0] res;
    int seen;

    reset         = 1'b1;
    cmd_valid     = 1'b0;
    cmd_op        = 2'b00;
    cmd_hd_bloco  = '0;
    cmd_ram_bloco = '0;
    cmd_nome      = '0;
    hdr_idx       = '0;
    for (int i = 0; i < HDB*W; i++) exp_hd[i] = pat_hd(i);
    for (int i = 0; i < 16*W; i++) exp_ram[i] = pat_ram(i);
    for (int i = 0; i < 16; i++) m_hdr[i] = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    chk("rst_bloco", 32'(bloco_resultado), 32'd0);
    chk("rst_ocupados", 32'(ocupados), 32'd0);
    chk("rst_we", 32'({hd_we, ram_we}), 32'd0);
    chk("rst_addr", 32'({hd_addr, ram_addr}), 32'd0);
    chk("rst_wdata", hd_wdata | ram_wdata, 32'd0);

    // First load: HD block 3 lands in RAM block 0.
    run_cmd(2'b01, 3, 0, 31'h1234, 1'b0, lat, res);
    chk("lit_lat_carga0", 32'(lat), 32'd7);
    chk("lit_res_carga0", 32'(res), 32'd0);
    hdr_idx = 4'd0;
    #1;
    chk("lit_hdr0", hdr_dado, 32'h8000_1234);
    chk("lit_ocup0", 32'(ocupados), 32'h0001);
    for (int k = 0; k < W; k++) chk("lit_ram_blk0", ram_mem[k], pat_hd(12 + k));

    run_cmd(2'b01, 7, 0, 31'h11, 1'b0, lat, res);
    run_cmd(2'b01, 9, 0, 31'h22, 1'b0, lat, res);
    run_cmd(2'b01, 10, 0, 31'h33, 1'b0, lat, res);
    chk("lit_lat_slot3", 32'(lat), 32'd10);
    chk("lit_res_slot3", 32'(res), 32'd3);

    // Free block 1, next load must reuse it rather than slot 4.
    run_cmd(2'b11, 0, 1, 31'h0, 1'b0, lat, res);
    run_cmd(2'b01, 11, 0, 31'h44, 1'b0, lat, res);
    chk("lit_res_reuso", 32'(res), 32'd1);

    run_cmd(2'b10, 5, 2, 31'h0, 1'b0, lat, res);
    chk("lit_lat_wb", 32'(lat), 32'd6);
    for (int k = 0; k < W; k++) chk("lit_wb_hd", hd_mem[20 + k], pat_hd(9*W + k));

    // Write-back and free of a free block, then a no-op.
    run_cmd(2'b10, 8, 9, 31'h0, 1'b0, lat, res);
    run_cmd(2'b11, 0, 9, 31'h0, 1'b0, lat, res);
    run_cmd(2'b00, 1, 2, 31'h7, 1'b0, lat, res);
    chk("lit_lat_nop", 32'(lat), 32'd1);

    for (int j = 0; j < 12; j++) run_cmd(2'b01, 20 + j, 0, 31'(32'h100 + j), 1'b0, lat, res);
    run_cmd(2'b01, 40, 0, 31'h999, 1'b0, lat, res);
    chk("lit_lat_cheia", 32'(lat), 32'd17);
    chk("lit_ocup_cheia", 32'(ocupados), 32'hFFFF);

    run_cmd(2'b11, 0, 5, 31'h0, 1'b0, lat, res);

    // Reset in COPIA cycle 2 of a load into slot 5 from HD block 6.
    @(negedge clk);
    cmd_valid     = 1'b1;
    cmd_op        = 2'b01;
    cmd_hd_bloco  = HDB_W'(6);
    cmd_ram_bloco = 4'd0;
    cmd_nome      = 31'h77;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    seen = 0;
    for (int c = 0; c < 40 && seen < 2; c++) begin
      @(negedge clk);
      if (ram_we) seen++;
    end
    chk("rst_copia_alcancado", 32'(seen), 32'd2);
    chk("pre_rst_ocup", 32'(ocupados), 32'hFFFF);
    hdr_idx = 4'd0;
    reset = 1'b1;
    #1;
    chk("rstmid_we", 32'({hd_we, ram_we}), 32'd0);
    chk("rstmid_addr", 32'({hd_addr, ram_addr}), 32'd0);
    chk("rstmid_wdata", hd_wdata | ram_wdata, 32'd0);
    chk("rstmid_done_erro", 32'({done, erro}), 32'd0);
    chk("rstmid_bloco", 32'(bloco_resultado), 32'd0);
    chk("rstmid_ocup", 32'(ocupados), 32'd0);
    chk("rstmid_hdr0", hdr_dado, 32'd0);
    for (int i = 0; i < 16; i++) m_hdr[i] = '0;
    exp_ram[5*W] = exp_hd[6*W];
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("pos_rst_ready", 32'(cmd_ready), 32'd1);
    chk_mem();

    // Busy-time command (free block 0) must be neither taken nor queued.
    run_cmd(2'b01, 2, 0, 31'h55, 1'b1, lat, res);
    chk("lit_res_ocupado", 32'(res), 32'd0);
    repeat (6) @(negedge clk);
    hdr_idx = 4'd0;
    #1;
    chk("lit_ocup_final", 32'(ocupados), 32'h0001);
    chk("lit_hdr_final", hdr_dado, 32'h8000_0055);
    chk_mem();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
